lu_cache_reader: RTL and testbench

- Downstream consumer of the LU cache's packed contents bus.
- On a start pulse it snapshots all cells and streams them out one per handshake, index 0 first. Cell 0 is the most recently used.
- While streaming it compares every cell against a latched key and reports hit and hit index.
- Lets a narrow sink, such as a UART or display driver, read the cache without racing its updates.

---
 rtl/lu_cache_reader_if.sv | 30 +++
 rtl/lu_cache_reader.sv | 110 +++++++++++
 tb/tb_lu_cache_reader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lu_cache_reader_if.sv
// Bundle of the signals between the LU cache reader and its sink/controller.
// The reader attaches to the slave modport; the controller/sink side uses master.
interface lu_cache_reader_if #(
  parameter int CELL_SIZE      = 8,
  parameter int CELL_COUNT     = 8,
  parameter int CELL_ADDR_SIZE = 3
);
  logic [CELL_COUNT-1:0][CELL_SIZE-1:0] cache_in;
  logic                                 start;
  logic [CELL_SIZE-1:0]                 key;
  logic                                 out_ready;
  logic [CELL_SIZE-1:0]                 out_data;
  logic [CELL_ADDR_SIZE-1:0]            out_index;
  logic                                 out_valid;
  logic                                 out_last;
  logic                                 busy;
  logic                                 done;
  logic                                 hit;
  logic [CELL_ADDR_SIZE-1:0]            hit_index;

  modport master (
    output cache_in, start, key, out_ready,
    input  out_data, out_index, out_valid, out_last, busy, done, hit, hit_index
  );

  modport slave (
    input  cache_in, start, key, out_ready,
    output out_data, out_index, out_valid, out_last, busy, done, hit, hit_index
  );
endinterface

// File: rtl/lu_cache_reader.sv
// Snapshots the LU cache contents on start, streams cells out one per handshake
// (cell 0 first, most recently used) and searches the snapshot for a latched key.
module lu_cache_reader #(
  parameter int CELL_SIZE      = 8,
  parameter int CELL_COUNT     = 8,
  parameter int CELL_ADDR_SIZE = 3
) (
  input  logic           clk,
  input  logic           reset,
  lu_cache_reader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CELL_ADDR_SIZE-1:0] LAST_IDX = CELL_ADDR_SIZE'(CELL_COUNT - 1);

  state_t                               r_state;
  state_t                               w_state_next;
  logic [CELL_COUNT-1:0][CELL_SIZE-1:0] r_snap;
  logic [CELL_SIZE-1:0]                 r_key;
  logic [CELL_ADDR_SIZE-1:0]            r_idx;
  logic                                 r_hit;
  logic [CELL_ADDR_SIZE-1:0]            r_hit_index;

  logic                                 w_accept;
  logic                                 w_xfer;
  logic                                 w_is_last;
  logic                                 w_match;
  logic [CELL_SIZE-1:0]                 w_cell;

  assign w_cell    = r_snap[r_idx];
  assign w_is_last = (r_idx == LAST_IDX);
  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_xfer    = (r_state == S_SCAN) && bus.out_ready;
  assign w_match   = (w_cell == r_key);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_SCAN;
      S_SCAN: if (bus.out_ready && w_is_last) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Hit tracking only records the first match, so duplicates report the lowest index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap      <= '0;
      r_key       <= '0;
      r_idx       <= '0;
      r_hit       <= 1'b0;
      r_hit_index <= '0;
    end else if (w_accept) begin
      r_snap      <= bus.cache_in;
      r_key       <= bus.key;
      r_idx       <= '0;
      r_hit       <= 1'b0;
      r_hit_index <= '0;
    end else if (w_xfer) begin
      if (!r_hit && w_match) begin
        r_hit       <= 1'b1;
        r_hit_index <= r_idx;
      end
      if (!w_is_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      S_SCAN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = w_cell;
        bus.out_index = r_idx;
        bus.out_last  = w_is_last;
        bus.busy      = 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.hit       = r_hit;
  assign bus.hit_index = r_hit_index;

endmodule

// File: tb/tb_lu_cache_reader.sv
// Scoreboard bench for lu_cache_reader: stimulus pushes expected beats and
// scan results; a negedge monitor pops and compares them as the DUT presents them.
module tb_lu_cache_reader;
  logic clk;
  logic reset;

  lu_cache_reader_if #(.CELL_SIZE(8), .CELL_COUNT(8), .CELL_ADDR_SIZE(3)) bus ();

  lu_cache_reader #(.CELL_SIZE(8), .CELL_COUNT(8), .CELL_ADDR_SIZE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] i;
    logic       l;
  } beat_t;

  typedef struct {
    logic       h;
    logic [2:0] hi;
  } res_t;

  beat_t bq[$];
  res_t  dq[$];
  int    errors = 0;
  int    checks = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic [2:0] prev_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares beats on handshake, hold-stability on stalls, results on done.
  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall && bus.out_valid) begin
        chk("stall_hold_data", 32'(bus.out_data), 32'(prev_d));
        chk("stall_hold_index", 32'(bus.out_index), 32'(prev_i));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_i     = bus.out_index;
      if (bus.out_valid && bus.out_ready) begin
        if (bq.size() == 0) begin
          chk("unexpected_beat", 32'(bus.out_index), 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = bq.pop_front();
          chk("beat_data", 32'(bus.out_data), 32'(b.d));
          chk("beat_index", 32'(bus.out_index), 32'(b.i));
          chk("beat_last", 32'(bus.out_last), 32'(b.l));
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          res_t r;
          r = dq.pop_front();
          chk("done_hit", 32'(bus.hit), 32'(r.h));
          chk("done_hit_index", 32'(bus.hit_index), 32'(r.hi));
          chk("done_beats_left", 32'(bq.size()), 32'd0);
          chk("done_valid_low", 32'(bus.out_valid), 32'd0);
          chk("done_busy", 32'(bus.busy), 32'd1);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_index"}, 32'(bus.out_index), 32'd0);
    chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_hit"}, 32'(bus.hit), 32'd0);
    chk({tag, "_hit_index"}, 32'(bus.hit_index), 32'd0);
  endtask

  // Loads cache_in, pulses start for one edge and queues the expected stream.
  task automatic start_scan(input logic [7:0] c [8], input logic [7:0] k,
                            input logic exp_hit, input logic [2:0] exp_idx,
                            input logic push_done);
    for (int unsigned i = 0; i < 8; i++) begin
      beat_t b;
      bus.cache_in[i] = c[i];
      b.d = c[i];
      b.i = 3'(i);
      b.l = (i == 7);
      bq.push_back(b);
    end
    if (push_done) begin
      res_t r;
      r.h  = exp_hit;
      r.hi = exp_idx;
      dq.push_back(r);
    end
    bus.key   = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_index", 32'(bus.out_index), 32'd0);
    chk("first_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    if (!bus.done) chk("done_timeout", 32'(n), 32'(budget + 1));
  endtask

  logic [7:0] cells_a [8];
  logic [7:0] cells_f [8];
  logic [7:0] cells_d [8];
  int         n;
  logic [3:0] rpat;

  initial begin
    cells_a = '{8'd7, 8'd3, 8'd9, 8'd5, 8'd1, 8'd8, 8'd6, 8'd4};
    cells_f = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    cells_d = '{8'h10, 8'h55, 8'h20, 8'h30, 8'h40, 8'h55, 8'h60, 8'h70};
    rpat    = 4'b1001;

    // Reset held with start and out_ready high: nothing moves.
    reset         = 1'b0;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    bus.key       = 8'h00;
    bus.cache_in  = '0;
    tick();
    tick();
    check_all_zero("rst");
    bus.start = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    check_all_zero("idle");

    // Full-speed scan, key present at index 2; done after 8 edges.
    start_scan(cells_a, 8'd9, 1'b1, 3'd2, 1'b1);
    wait_done(20, n);
    chk("scan_cycles", 32'(n), 32'd8);
    tick();
    chk("after_done_busy", 32'(bus.busy), 32'd0);
    chk("hold_hit", 32'(bus.hit), 32'd1);
    chk("hold_hit_index", 32'(bus.hit_index), 32'd2);

    // Miss.
    start_scan(cells_a, 8'd2, 1'b0, 3'd0, 1'b1);
    wait_done(20, n);
    tick();

    // Back-pressure with ready pattern 1,0,0,1.
    start_scan(cells_a, 8'd4, 1'b1, 3'd7, 1'b1);
    n = 0;
    while (!bus.done && n < 100) begin
      bus.out_ready = rpat[n % 4];
      tick();
      n++;
    end
    if (!bus.done) chk("bp_timeout", 32'(n), 32'd101);
    bus.out_ready = 1'b1;
    tick();

    // Snapshot isolation and start ignored mid-scan and in DONE.
    start_scan(cells_a, 8'd8, 1'b1, 3'd5, 1'b1);
    tick();
    tick();
    tick();
    for (int unsigned i = 0; i < 8; i++) bus.cache_in[i] = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(20, n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("done_start_ignored_valid", 32'(bus.out_valid), 32'd0);
    chk("done_start_ignored_busy", 32'(bus.busy), 32'd0);
    start_scan(cells_f, 8'hFF, 1'b1, 3'd0, 1'b1);
    wait_done(20, n);
    tick();

    // Duplicate key: lowest index wins.
    start_scan(cells_d, 8'h55, 1'b1, 3'd1, 1'b1);
    wait_done(20, n);
    tick();

    // Reset at beat 4 aborts without done.
    start_scan(cells_d, 8'h70, 1'b1, 3'd7, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("abort_at_index", 32'(bus.out_index), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    bq.delete();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    check_all_zero("post_abort");

    start_scan(cells_a, 8'd4, 1'b1, 3'd7, 1'b1);
    wait_done(20, n);
    chk("post_abort_cycles", 32'(n), 32'd8);
    tick();
    tick();
    chk("final_beats_left", 32'(bq.size()), 32'd0);
    chk("final_done_left", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
